// File: rtl/pcm_cmd_ctrl.sv
// pcm_cmd_ctrl: command controller for the parallel PCM (x16 flash-style command set).
// Accepts read-array / read-status / word-program / clear-status requests on a
// valid/ready port, sequences CE#/OE#/WE# bus cycles and returns data + error flag.
// Ports:
//   clk, rst (async, active high)
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata : request port
//   rsp_valid/rsp_data/rsp_err                     : one-cycle response
//   pcm_addr/pcm_data/pcm_rst_n/pcm_ce_n/pcm_oe_n/pcm_we_n : PCM pins
// Optional build macro PCM_TIMEOUT_EN: bounds program-status polling to POLL_MAX reads.
module pcm_cmd_ctrl #(
   parameter int ADDR_W   = 23,
   parameter int DATA_W   = 16,
   parameter int T_PWR    = 15,
   parameter int T_WE     = 6,
   parameter int T_RD     = 13,
`ifdef PCM_TIMEOUT_EN
   parameter int T_REC    = 1,
   parameter int POLL_MAX = 4096
`else
   parameter int T_REC    = 1
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] pcm_addr,
   inout  wire  [DATA_W-1:0] pcm_data,
   output logic              pcm_rst_n,
   output logic              pcm_ce_n,
   output logic              pcm_oe_n,
   output logic              pcm_we_n
);

   localparam int T_M1  = (T_PWR > T_WE) ? T_PWR : T_WE;
   localparam int T_M2  = (T_RD > T_REC) ? T_RD : T_REC;
   localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
   localparam int CNT_W = $clog2(T_MAX + 1);
`ifdef PCM_TIMEOUT_EN
   localparam int PW    = $clog2(POLL_MAX + 1);
`endif

   localparam logic [2:0] S_PWR  = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_BWL  = 3'd2;
   localparam logic [2:0] S_BWH  = 3'd3;
   localparam logic [2:0] S_BWR  = 3'd4;
   localparam logic [2:0] S_BRL  = 3'd5;
   localparam logic [2:0] S_BRR  = 3'd6;
   localparam logic [2:0] S_RSP  = 3'd7;

   logic [2:0]        r_state;
   logic [1:0]        r_op;
   logic              r_step;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_err;
`ifdef PCM_TIMEOUT_EN
   logic [PW-1:0]     r_poll;
`endif

   logic [DATA_W-1:0] w_bus_wd;
   logic              w_drive;
   logic              w_prog_err;

   // Word driven during a bus write: command code, or program data on step 1.
   always_comb begin
      w_bus_wd = '0;
      case (r_op)
         2'd0:    w_bus_wd = DATA_W'(16'h00FF);
         2'd1:    w_bus_wd = DATA_W'(16'h0070);
         2'd2:    w_bus_wd = r_step ? r_wdata : DATA_W'(16'h0040);
         default: w_bus_wd = DATA_W'(16'h0050);
      endcase
   end

   // Data is driven through the WE# low phase and the following hold cycle.
   assign w_drive    = (r_state == S_BWL) || (r_state == S_BWH);
   assign w_prog_err = r_rdata[4] | r_rdata[3] | r_rdata[1];

   assign pcm_data  = w_drive ? w_bus_wd : {DATA_W{1'bz}};
   assign pcm_addr  = r_addr;
   assign pcm_rst_n = ~rst;
   assign pcm_we_n  = (r_state != S_BWL);
   assign pcm_oe_n  = (r_state != S_BRL);
   assign pcm_ce_n  = (r_state != S_BWL) && (r_state != S_BRL);
   assign cmd_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RSP);
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_PWR;
         r_op       <= '0;
         r_step     <= 1'b0;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
`ifdef PCM_TIMEOUT_EN
         r_poll     <= '0;
`endif
      end else begin
         case (r_state)
            S_PWR: begin
               if (r_cnt == CNT_W'(T_PWR - 1)) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_IDLE: begin
               if (cmd_valid) begin
                  r_op    <= cmd_op[1:0];
                  r_addr  <= cmd_addr;
                  r_wdata <= cmd_wdata;
                  r_step  <= 1'b0;
                  r_cnt   <= '0;
`ifdef PCM_TIMEOUT_EN
                  r_poll  <= '0;
`endif
                  // Ops 4..7 are rejected without touching the bus.
                  if (cmd_op[2]) begin
                     r_rsp_data <= '0;
                     r_rsp_err  <= 1'b1;
                     r_state    <= S_RSP;
                  end else begin
                     r_state <= S_BWL;
                  end
               end
            end
            S_BWL: begin
               if (r_cnt == CNT_W'(T_WE - 1)) begin
                  r_cnt   <= '0;
                  r_state <= S_BWH;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_BWH: r_state <= S_BWR;
            S_BWR: begin
               if (r_cnt == CNT_W'(T_REC - 1)) begin
                  r_cnt <= '0;
                  if (r_op == 2'd3) begin
                     r_rsp_data <= '0;
                     r_rsp_err  <= 1'b0;
                     r_state    <= S_RSP;
                  end else if (r_op == 2'd2 && !r_step) begin
                     r_step  <= 1'b1;
                     r_state <= S_BWL;
                  end else begin
                     r_state <= S_BRL;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_BRL: begin
               if (r_cnt == CNT_W'(T_RD - 1)) begin
                  r_rdata <= pcm_data;
                  r_cnt   <= '0;
                  r_state <= S_BRR;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_BRR: begin
               if (r_cnt == CNT_W'(T_REC - 1)) begin
                  r_cnt <= '0;
                  if (r_op != 2'd2) begin
                     r_rsp_data <= r_rdata;
                     r_rsp_err  <= 1'b0;
                     r_state    <= S_RSP;
                  end else if (r_rdata[7]) begin
                     r_rsp_data <= r_rdata;
                     r_rsp_err  <= w_prog_err;
                     r_state    <= S_RSP;
`ifdef PCM_TIMEOUT_EN
                  end else if (r_poll == PW'(POLL_MAX - 1)) begin
                     r_rsp_data <= r_rdata;
                     r_rsp_err  <= 1'b1;
                     r_state    <= S_RSP;
                  end else begin
                     r_poll  <= r_poll + 1'b1;
                     r_state <= S_BRL;
                  end
`else
                  end else begin
                     r_state <= S_BRL;
                  end
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RSP:   r_state <= S_IDLE;
            default: r_state <= S_PWR;
         endcase
      end
   end

endmodule
